// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//   Control sequencer for an 8-point radix-2 FFT/IFFT datapath. Each accepted start
//   runs one frame: an input load strobe, then butterfly stages 1..3. Each stage gets
//   a single-cycle enable, and the sequencer waits for that stage's ready. The frame
//   ends with a done pulse. The block also latches the FFT/IFFT mode, counts completed
//   frames and keeps a sticky overrun flag.
//
//   Optional feature macro: FFT_TIMEOUT_EN
//     When this macro is defined, a per-stage watchdog moves the FSM to ERR if a stage
//     stays silent for TIMEOUT cycles. When it is undefined, ERR is unreachable and
//     err_o is tied low.
//
//   Every output is decoded from registered state, so no input reaches an output
//   combinationally.

module fft_stage_sequencer #(
  parameter int unsigned FRAME_W = 32'd8,
  parameter int unsigned TO_W    = 32'd5,
  parameter int unsigned TIMEOUT = 32'd16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic               abort_i,
  input  logic [2:0]         stage_ready_i,
  output logic               load_en_o,
  output logic [2:0]         stage_en_o,
  output logic [1:0]         stage_o,
  output logic               mode_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [FRAME_W-1:0] frame_cnt_o,
  output logic               ovr_o,
  output logic               err_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_S1   = 3'd2,
    ST_S2   = 3'd3,
    ST_S3   = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic                 first_q, first_d;     // high in the entry cycle of S1/S2/S3
  logic                 mode_q, mode_d;
  logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                 ovr_q, ovr_d;
  logic                 err_q, err_d;

  logic                 in_stage_s;           // FSM is in S1, S2 or S3
  logic                 ready_s;              // ready of the stage currently running
  logic                 timeout_s;            // watchdog expired in the current stage
  logic                 accept_s;             // a start is accepted this cycle

  // Select the ready bit of the active stage
  always_comb begin
    in_stage_s = 1'b0;
    ready_s    = 1'b0;
    case (state_q)
      ST_S1:   begin in_stage_s = 1'b1; ready_s = stage_ready_i[0]; end
      ST_S2:   begin in_stage_s = 1'b1; ready_s = stage_ready_i[1]; end
      ST_S3:   begin in_stage_s = 1'b1; ready_s = stage_ready_i[2]; end
      default: begin in_stage_s = 1'b0; ready_s = 1'b0; end
    endcase
  end

`ifdef FFT_TIMEOUT_EN
  logic [TO_W-1:0] wd_q, wd_d;

  assign timeout_s = in_stage_s && (wd_q == TO_W'(TIMEOUT - 32'd1));

  // Watchdog: cleared on every state change, counts each cycle spent inside a stage
  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q) begin
      wd_d = {TO_W{1'b0}};
    end else if (in_stage_s) begin
      wd_d = wd_q + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      wd_d = {TO_W{1'b0}};
    end
  end

  // Watchdog register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= {TO_W{1'b0}};
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic cfg_unused_s;

  assign timeout_s    = 1'b0;
  assign cfg_unused_s = (TO_W == 32'd0) ^ (TIMEOUT == 32'd0);
`endif

  // Next-state logic: abort beats everything, ready beats the watchdog, stale ready ignored
  always_comb begin
    state_d = state_q;
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = start_i ? ST_LOAD : ST_IDLE;
        ST_LOAD: state_d = ST_S1;
        ST_S1:   state_d = (!first_q && ready_s) ? ST_S2   : (timeout_s ? ST_ERR : ST_S1);
        ST_S2:   state_d = (!first_q && ready_s) ? ST_S3   : (timeout_s ? ST_ERR : ST_S2);
        ST_S3:   state_d = (!first_q && ready_s) ? ST_DONE : (timeout_s ? ST_ERR : ST_S3);
        ST_DONE: state_d = start_i ? ST_LOAD : ST_IDLE;
        ST_ERR:  state_d = start_i ? ST_LOAD : ST_ERR;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Frame bookkeeping: entry flag, latched mode, frame counter and sticky flags
  always_comb begin
    accept_s    = (state_d == ST_LOAD) && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    first_d     = (state_d inside {ST_S1, ST_S2, ST_S3}) && (state_d != state_q);
    mode_d      = accept_s ? mode_i : mode_q;
    frame_cnt_d = frame_cnt_q;
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      frame_cnt_d = frame_cnt_q + {{(FRAME_W-1){1'b0}}, 1'b1};
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    ovr_d = ovr_q;
    if (accept_s) begin
      ovr_d = 1'b0;
    end else if (start_i && !abort_i && (state_q inside {ST_LOAD, ST_S1, ST_S2, ST_S3})) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_q;
    end
    err_d = err_q;
    if (accept_s) begin
      err_d = 1'b0;
    end else if ((state_q == ST_ERR) && abort_i) begin
      err_d = 1'b0;
    end else if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      first_q     <= 1'b0;
      mode_q      <= 1'b0;
      frame_cnt_q <= {FRAME_W{1'b0}};
      ovr_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      ovr_q       <= ovr_d;
      err_q       <= err_d;
    end
  end

  // Output decode from registered state; stage enables only in a stage's entry cycle
  always_comb begin
    load_en_o  = 1'b0;
    stage_en_o = 3'b000;
    stage_o    = 2'd0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      ST_IDLE: busy_o = 1'b0;
      ST_LOAD: begin load_en_o = 1'b1; busy_o = 1'b1; end
      ST_S1:   begin stage_en_o = {2'b00, first_q};        stage_o = 2'd1; busy_o = 1'b1; end
      ST_S2:   begin stage_en_o = {1'b0, first_q, 1'b0};   stage_o = 2'd2; busy_o = 1'b1; end
      ST_S3:   begin stage_en_o = {first_q, 2'b00};        stage_o = 2'd3; busy_o = 1'b1; end
      ST_DONE: begin done_o = 1'b1; busy_o = 1'b1; end
      ST_ERR:  busy_o = 1'b0;
      default: busy_o = 1'b0;
    endcase
  end

  assign mode_o      = mode_q;
  assign frame_cnt_o = frame_cnt_q;
  assign ovr_o       = ovr_q;
  assign err_o       = err_q;

endmodule
